execute_cycle: RTL
==================

// Module: execute_cycle
// PURPOSE
//   Execute stage of the 5-stage pipeline, directly upstream of memory stage.
//   - Computes the ALU result from decoded operands.
//   - Runs an optional 32-cycle iterative shift-add multiplier, stalling upstream while busy.
//   - Holds the EX/MEM pipeline register whose outputs drive the memory stage.
// PARAMETERS
//   XLEN        32  datapath width (operands, result, store data)
//   REG_ADDR_W  5   destination register index width
// PORTS
//   clk        in   1           single clock, all state on posedge
//   rst        in   1           asynchronous, active-low reset
//   Valid_in   in   1           decode presents a valid instruction
//   Flush      in   1           sync: kill instruction in EX, abort multiply
//   RegW       in   1           register-write control from decode
//   Mem_R      in   1           memory-read control from decode
//   Mem_W      in   1           memory-write control from decode
//   WB         in   1           writeback-select control (1 = memory data)
//   ALU_Op     in   4           operation select, see BEHAVIOUR
//   ALU_Src    in   1           0: B = Src2, 1: B = Imm
//   Src1       in   XLEN        operand A
//   Src2       in   XLEN        operand B / store data
//   Imm        in   XLEN        sign-extended immediate
//   Rd1        in   REG_ADDR_W  destination register index
//   Stall      out  1           upstream must hold its outputs this cycle
//   RegW_out, Mem_R_out, Mem_W_out, WB_out  out 1   registered controls to memory stage
//   Alu_Res    out  XLEN        registered result / memory address
//   Data_in    out  XLEN        registered store data (Src2)
//   Rd2        out  REG_ADDR_W  registered destination index
// BEHAVIOUR
//   - Reset (rst=0, async): all registered outputs 0, FSM IDLE, counter 0, Stall 0.
//   - ALU_Op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//     8 SLT (signed, result 0/1), 9 SLTU, 10 MUL; all other codes give result 0.
//   - ADD/SUB/MUL wrap mod 2^XLEN (MUL keeps low XLEN bits).
//   - Shift amount is B[4:0]; SRA replicates A[XLEN-1].
//   - Single-cycle ops: EX/MEM captures result, controls, Src2 and Rd1 on the next edge.
//     Latency is 1 cycle. Valid_in=0 captures a bubble: controls and Rd2 are 0.
//   - Multiplier FSM states:
//     - IDLE: Valid_in & ALU_Op==10 & !Flush -> Stall=1; latch A, B; cnt=0; go BUSY.
//     - BUSY: Stall=1; one add-shift per edge; cnt++.
//       After the edge with cnt==XLEN-1, go DONE.
//     - DONE: Stall=0; EX/MEM captures the product with MUL's controls; go IDLE.
//       No new start is evaluated in DONE.
//   - MUL occupies EX for XLEN+2 = 34 cycles.
//     Every cycle with Stall=1 captures a bubble into EX/MEM.
//   - Stall is combinational:
//     (IDLE & Valid_in & ALU_Op==10 & !Flush) | BUSY.
//   - Flush: EX/MEM captures a bubble and FSM returns to IDLE on the same edge.
//     Flush has priority over start, BUSY and DONE. Stall is 0 in a Flush cycle.
//   - Reset mid-multiply: product discarded, FSM IDLE, no spurious write.
// CONFIGURATION
//   EXEC_MUL_EN defined: multiplier FSM and op 10 as above.
//   EXEC_MUL_EN undefined: no FSM or multiplier logic; op 10 yields result 0.
//     Stall is tied 0 and every op takes 1 cycle.
// TESTING
//   1. Reset: hold rst=0 with random inputs -> all outputs 0, Stall 0;
//      release -> first valid ADD lands next edge.
//   2. ADD Src1=0xFFFFFFFF, Src2=1, ALU_Src=0, Rd1=3, RegW=1
//      -> Alu_Res=0x00000000, Rd2=3, RegW_out=1 after 1 edge.
//   3. SRA Src1=0x80000000, Imm=4, ALU_Src=1 -> 0xF8000000;
//      SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
//   4. MUL 0x00012345 x 0x00000100, Rd1=7, RegW=1 (EXEC_MUL_EN):
//      - Stall high for 33 cycles, bubbles meanwhile.
//      - Edge 34 gives Alu_Res=0x01234500, Rd2=7.
//   5. Flush asserted on 10th BUSY cycle -> Stall 0 that cycle,
//      next EX/MEM is a bubble, FSM IDLE, next ADD completes in 1 cycle.
//   6. rst pulsed low on 20th BUSY cycle -> outputs 0 immediately,
//      no product ever appears; build without EXEC_MUL_EN: MUL -> 0, Stall never 1.

Source files
------------

// File: rtl/execute_cycle.sv
// -----------------------------------------------------------------------------
// execute_cycle : EX stage of the 5-stage pipeline, feeding the memory stage.
//
// Computes the ALU result from decoded operands and registers result, controls,
// store data and destination index into the EX/MEM pipeline register.
//
// Build option: define EXEC_MUL_EN to add a 32-step iterative shift-add
// multiplier (ALU_Op 10). While it runs, Stall holds decode and bubbles
// are written into EX/MEM. Without EXEC_MUL_EN, op 10 yields 0, Stall is
// tied low and every op completes in one cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   Valid_in, Flush          instruction valid / kill instruction in EX
//   RegW, Mem_R, Mem_W, WB   control bits from decode
//   ALU_Op, ALU_Src          operation select, B-operand select (1 = Imm)
//   Src1, Src2, Imm, Rd1     operands, immediate, destination index
//   Stall                    upstream must hold its outputs (combinational)
//   RegW_out .. WB_out       registered controls to memory stage
//   Alu_Res, Data_in, Rd2    registered result/address, store data, dest index
// -----------------------------------------------------------------------------
module execute_cycle #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_in,
  input  logic                  Flush,
  input  logic                  RegW,
  input  logic                  Mem_R,
  input  logic                  Mem_W,
  input  logic                  WB,
  input  logic [3:0]            ALU_Op,
  input  logic                  ALU_Src,
  input  logic [XLEN-1:0]       Src1,
  input  logic [XLEN-1:0]       Src2,
  input  logic [XLEN-1:0]       Imm,
  input  logic [REG_ADDR_W-1:0] Rd1,
  output logic                  Stall,
  output logic                  RegW_out,
  output logic                  Mem_R_out,
  output logic                  Mem_W_out,
  output logic                  WB_out,
  output logic [XLEN-1:0]       Alu_Res,
  output logic [XLEN-1:0]       Data_in,
  output logic [REG_ADDR_W-1:0] Rd2
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  // EX/MEM pipeline register contents; all-zero is a bubble.
  typedef struct packed {
    logic                  regw;
    logic                  memr;
    logic                  memw;
    logic                  wb;
    logic [XLEN-1:0]       res;
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_t;

  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  exmem_t          alu_ex;
  exmem_t          exmem_d;
  exmem_t          exmem_q;

  assign op_b  = ALU_Src ? Imm : Src2;
  assign shamt = op_b[SHW-1:0];

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. Op 10 (and unused codes) fall to 0 here; in the
  // multiplier build the product comes from the iterative path instead.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    case (ALU_Op)
      OP_ADD:  alu_res = Src1 + op_b;
      OP_SUB:  alu_res = Src1 - op_b;
      OP_AND:  alu_res = Src1 & op_b;
      OP_OR:   alu_res = Src1 | op_b;
      OP_XOR:  alu_res = Src1 ^ op_b;
      OP_SLL:  alu_res = Src1 << shamt;
      OP_SRL:  alu_res = Src1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(Src1) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(Src1) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (Src1 < op_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_ex      = '0;
    alu_ex.regw = RegW;
    alu_ex.memr = Mem_R;
    alu_ex.memw = Mem_W;
    alu_ex.wb   = WB;
    alu_ex.res  = alu_res;
    alu_ex.data = Src2;
    alu_ex.rd   = Rd1;
  end

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            start;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  exmem_t          mul_ex_q;   // MUL's controls/rd/store data, held for DONE

  // Next state and Stall. Flush (and reset) override every state: no start,
  // no stall, straight back to IDLE.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Valid_in && (ALU_Op == OP_MUL)) begin
          start   = 1'b1;
          Stall   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == SHW'(XLEN-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;   // product written this edge; no new start
      default: state_d = IDLE;
    endcase
    if (Flush || !rst) begin
      start   = 1'b0;
      Stall   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Shift-add datapath: multiplicand walks left, multiplier walks right,
  // accumulator keeps the low XLEN bits of the running product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_ex_q <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= Src1;
      mplier_q <= op_b;
      mul_ex_q <= alu_ex;
    end else if (Flush) begin
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
    end
  end

  // EX/MEM input: start and BUSY cycles write bubbles, DONE writes the product.
  always_comb begin
    exmem_d = '0;
    if (Flush) begin
      exmem_d = '0;
    end else if (state_q == DONE) begin
      exmem_d     = mul_ex_q;
      exmem_d.res = acc_q;
    end else if ((state_q == IDLE) && !start && Valid_in) begin
      exmem_d = alu_ex;
    end
  end
`else
  assign Stall = 1'b0;

  always_comb begin
    exmem_d = '0;
    if (Valid_in && !Flush) exmem_d = alu_ex;
  end
`endif

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exmem_q <= '0;
    else      exmem_q <= exmem_d;
  end

  assign RegW_out  = exmem_q.regw;
  assign Mem_R_out = exmem_q.memr;
  assign Mem_W_out = exmem_q.memw;
  assign WB_out    = exmem_q.wb;
  assign Alu_Res   = exmem_q.res;
  assign Data_in   = exmem_q.data;
  assign Rd2       = exmem_q.rd;

endmodule
